// File: rtl/load_store_queue.sv
// load_store_queue
//   In-order circular FIFO of lsq_entry_t records, one per dispatched load or
//   store. Dispatch/rename pushes at the tail; the memory arbiter reads the
//   oldest entry combinationally on lsq_head and pops it on D-cache response.
//   A mispredict drops every entry, since all queued memory ops are younger
//   than the resolving branch.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   mispredict  flush request from ROB/branch resolution
//   push        enqueue push_entry
//   push_entry  lsq_entry_t record to enqueue
//   full        no free entry; dispatch must stall
//   pop         retire the head entry
//   lsq_head    oldest entry (payload undefined when lsq_empty)
//   lsq_empty   queue holds no entries
//   count       number of occupied entries, 0..DEPTH

package lsq_pkg;
   typedef struct packed {
      logic        store_load_inst;
      logic [5:0]  ps1_s;
      logic [5:0]  ps2_s;
      logic [5:0]  pd_s;
      logic [4:0]  rob_num;
      logic [31:0] rvfi_data;
   } lsq_entry_t;
endpackage

module load_store_queue
   import lsq_pkg::*;
#(
   parameter  int unsigned DEPTH    = 8,
   localparam int unsigned PTR_BITS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mispredict,
   input  logic                push,
   input  lsq_entry_t          push_entry,
   output logic                full,
   input  logic                pop,
   output lsq_entry_t          lsq_head,
   output logic                lsq_empty,
   output logic [PTR_BITS:0]   count
);

   lsq_entry_t          mem [DEPTH];
   logic [PTR_BITS:0]   head_ptr;
   logic [PTR_BITS:0]   tail_ptr;
   logic                push_ok;
   logic                pop_ok;

   // Flags depend only on registered pointers, never on push/pop, so full
   // timing stays independent of the arbiter (no full-plus-pop bypass).
   always_comb begin
      lsq_empty = (head_ptr == tail_ptr);
      full      = (head_ptr[PTR_BITS-1:0] == tail_ptr[PTR_BITS-1:0]) &&
                  (head_ptr[PTR_BITS] != tail_ptr[PTR_BITS]);
      count     = tail_ptr - head_ptr;
      lsq_head  = mem[head_ptr[PTR_BITS-1:0]];
   end

   always_comb begin
      push_ok = push && !full      && !mispredict && rst;
      pop_ok  = pop  && !lsq_empty && !mispredict && rst;
   end

   // Pointer increments roll over naturally through the wrap bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
      end else if (mispredict) begin
         head_ptr <= '0;
         tail_ptr <= '0;
      end else begin
         if (push_ok) tail_ptr <= tail_ptr + 1'b1;
         if (pop_ok)  head_ptr <= head_ptr + 1'b1;
      end
   end

   // Storage is not reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[tail_ptr[PTR_BITS-1:0]] <= push_entry;
   end

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;
   import lsq_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic       clk;
   logic       rst;
   logic       mispredict;
   logic       push;
   lsq_entry_t push_entry;
   logic       full;
   logic       pop;
   lsq_entry_t lsq_head;
   logic       lsq_empty;
   logic [3:0] count;

   int n_tests;
   int n_fail;

   load_store_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .mispredict (mispredict),
      .push       (push),
      .push_entry (push_entry),
      .full       (full),
      .pop        (pop),
      .lsq_head   (lsq_head),
      .lsq_empty  (lsq_empty),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic lsq_entry_t mk(input int unsigned n);
      lsq_entry_t e;
      e.store_load_inst = n[0];
      e.ps1_s           = n[6:1];
      e.ps2_s           = n[11:6];
      e.pd_s            = n[5:0] ^ 6'h2A;
      e.rob_num         = n[4:0];
      e.rvfi_data       = 32'hA500_0000 ^ n;
      return e;
   endfunction

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0; pop = 1'b0; mispredict = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; push = 1'b1; pop = 1'b0; mispredict = 1'b0;
      push_entry = mk(99);
      tick(); tick();
      n_tests++; if (lsq_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", lsq_empty); end
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      rst = 1'b1; idle();
      tick();
      n_tests++; if (count !== 4'd0 || lsq_empty !== 1'b1) begin n_fail++; $display("FAIL reset_release count %0d empty %b exp 0/1", count, lsq_empty); end
   endtask

   task automatic test_ordering();
      for (int i = 1; i <= 8; i++) begin
         push = 1'b1; push_entry = mk(i);
         tick();
         n_tests++; if (count !== 4'(i)) begin n_fail++; $display("FAIL order_fill_count got %0d exp %0d", count, i); end
      end
      idle();
      n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL order_full got %b exp 1", full); end
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL order_count8 got %0d exp 8", count); end
      for (int i = 1; i <= 8; i++) begin
         n_tests++; if (lsq_head !== mk(i)) begin n_fail++; $display("FAIL order_head got %h exp %h", lsq_head, mk(i)); end
         pop = 1'b1;
         tick();
      end
      idle();
      n_tests++; if (lsq_empty !== 1'b1) begin n_fail++; $display("FAIL order_drained_empty got %b exp 1", lsq_empty); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) begin
         push = 1'b1; push_entry = mk(i);
         tick();
      end
      push_entry = mk(9);
      tick();
      idle();
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d exp 8", count); end
      n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", full); end
      for (int i = 1; i <= 8; i++) begin
         n_tests++; if (lsq_head !== mk(i)) begin n_fail++; $display("FAIL ovf_head got %h exp %h", lsq_head, mk(i)); end
         pop = 1'b1;
         tick();
      end
      n_tests++; if (lsq_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got %b exp 1", lsq_empty); end
      // pop still asserted while empty
      tick();
      idle();
      n_tests++; if (count !== 4'd0 || lsq_empty !== 1'b1) begin n_fail++; $display("FAIL unf_count got %0d/%b exp 0/1", count, lsq_empty); end
      push = 1'b1; push_entry = mk(20);
      tick();
      idle();
      n_tests++; if (lsq_head !== mk(20) || count !== 4'd1) begin n_fail++; $display("FAIL unf_ptrs head %h cnt %0d exp %h 1", lsq_head, count, mk(20)); end
      pop = 1'b1; tick(); idle();
   endtask

   task automatic test_concurrent();
      lsq_entry_t exp_q[$];
      lsq_entry_t e;
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; push_entry = mk(100 + i); exp_q.push_back(mk(100 + i));
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         n_tests++; if (lsq_head !== exp_q[0]) begin n_fail++; $display("FAIL conc_head got %h exp %h", lsq_head, exp_q[0]); end
         push = 1'b1; pop = 1'b1; push_entry = mk(103 + k);
         tick();
         e = exp_q.pop_front();
         exp_q.push_back(mk(103 + k));
         n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL conc_count got %0d exp 3", count); end
      end
      idle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++; if (lsq_head !== e) begin n_fail++; $display("FAIL conc_drain got %h exp %h", lsq_head, e); end
         pop = 1'b1; tick(); idle();
      end
      // full + push + pop: pop accepted, push dropped
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; push_entry = mk(150 + i);
         tick();
      end
      push = 1'b1; pop = 1'b1; push_entry = mk(200);
      tick();
      idle();
      n_tests++; if (count !== 4'd7) begin n_fail++; $display("FAIL fullpp_count got %0d exp 7", count); end
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL fullpp_full got %b exp 0", full); end
      for (int i = 1; i < 8; i++) begin
         n_tests++; if (lsq_head !== mk(150 + i)) begin n_fail++; $display("FAIL fullpp_head got %h exp %h", lsq_head, mk(150 + i)); end
         pop = 1'b1; tick(); idle();
      end
      n_tests++; if (lsq_empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_dropped empty got %b exp 1", lsq_empty); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         push = 1'b1; push_entry = mk(250 + i);
         tick();
      end
      mispredict = 1'b1; push = 1'b1; pop = 1'b1; push_entry = mk(299);
      tick();
      idle();
      n_tests++; if (lsq_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", lsq_empty); end
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b exp 0", full); end
      push = 1'b1; push_entry = mk(300);
      tick();
      idle();
      n_tests++; if (lsq_head !== mk(300) || count !== 4'd1) begin n_fail++; $display("FAIL flush_repush head %h cnt %0d exp %h 1", lsq_head, count, mk(300)); end
      pop = 1'b1; tick(); idle();
   endtask

   task automatic test_random();
      lsq_entry_t sb[$];
      lsq_entry_t e;
      logic p, q, m, p_ok, q_ok;
      for (int c = 0; c < 10000; c++) begin
         p = ($urandom_range(99) < 60);
         q = ($urandom_range(99) < 50);
         m = ($urandom_range(99) < 2);
         push = p; pop = q; mispredict = m;
         push_entry = mk($urandom);
         p_ok = p && (sb.size() < DEPTH) && !m;
         q_ok = q && (sb.size() > 0) && !m;
         e = push_entry;
         tick();
         if (m) sb.delete();
         else begin
            if (q_ok) void'(sb.pop_front());
            if (p_ok) sb.push_back(e);
         end
         n_tests++; if (count !== 4'(sb.size())) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, count, sb.size()); end
         n_tests++; if (full !== (sb.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full cyc %0d got %b exp %b", c, full, sb.size() == DEPTH); end
         n_tests++; if (lsq_empty !== (sb.size() == 0)) begin n_fail++; $display("FAIL rand_empty cyc %0d got %b exp %b", c, lsq_empty, sb.size() == 0); end
         if (sb.size() > 0) begin
            n_tests++; if (lsq_head !== sb[0]) begin n_fail++; $display("FAIL rand_head cyc %0d got %h exp %h", c, lsq_head, sb[0]); end
         end
      end
      idle();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      idle();
      push_entry = '0;
      test_reset();
      test_ordering();
      test_overflow();
      test_concurrent();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
